// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: program counter and instruction-fetch front end (IF stage).
// Holds the PC, issues one fetch at a time to instruction memory, and hands
// {pc, instr, pc_plus4} to decode over a valid/ready handshake. Redirects from
// later stages override everything and cancel any fetch still in flight.
// Optional build macro: PC_ALIGN_CHECK_EN adds if_addr_err and turns a
// misaligned redirect into a nop delivery instead of a memory request.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
    parameter int unsigned PC_STEP      = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req_valid,
    input  logic        imem_req_ready,
    output logic [31:0] imem_req_addr,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic        if_valid,
    input  logic        if_ready,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc_plus4
`ifdef PC_ALIGN_CHECK_EN
    ,
    output logic        if_addr_err
`endif
);

    localparam logic [31:0] STEP = 32'(PC_STEP);

    typedef enum logic [1:0] {
        S_REQ  = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        kill;
    logic        kill_next;
    logic        capture;
    logic        req_accept;
    logic [31:0] pc_plus;
    logic [31:0] target_eff;
    logic [31:0] target_plus;

`ifdef PC_ALIGN_CHECK_EN
    logic        capture_err;
    logic        redirect_misaligned;

    assign target_eff          = redirect_target;
    assign redirect_misaligned = redirect_valid && (redirect_target[1:0] != 2'b00);
`else
    assign target_eff = redirect_target & ~32'h0000_0003;
`endif

    assign req_accept    = imem_req_valid && imem_req_ready;
    assign imem_req_addr = pc;
    assign pc_plus       = pc + STEP;
    assign target_plus   = target_eff + STEP;

    // State register; reset always restarts fetching from the reset vector.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_REQ;
        end else begin
            state <= state_next;
        end
    end

    // Next-state, next-PC and kill decisions; a redirect outranks every other event.
    always_comb begin
        state_next = state;
        pc_next    = pc;
        kill_next  = kill;
        capture    = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        capture_err = 1'b0;
`endif
        case (state)
            S_REQ: begin
                if (redirect_valid) begin
                    pc_next = target_eff;
                    if (req_accept) begin
                        state_next = S_WAIT;
                        kill_next  = 1'b1;
                    end
                end else if (req_accept) begin
                    state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_next = target_eff;
                    if (imem_rsp_valid) begin
                        state_next = S_REQ;
                        kill_next  = 1'b0;
                    end else begin
                        kill_next = 1'b1;
                    end
                end else if (imem_rsp_valid) begin
                    state_next = kill ? S_REQ : S_HOLD;
                    kill_next  = 1'b0;
                    capture    = !kill;
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_next    = target_eff;
                    state_next = S_REQ;
                end else if (if_ready) begin
                    pc_next    = pc_plus;
                    state_next = S_REQ;
                end
            end
            default: begin
                state_next = S_REQ;
            end
        endcase
`ifdef PC_ALIGN_CHECK_EN
        if (redirect_misaligned) begin
            state_next  = S_HOLD;
            capture_err = 1'b1;
        end
`endif
    end

    // PC, kill flag, registered request/valid strobes and the decode-facing holding registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc             <= RESET_VECTOR;
            kill           <= 1'b0;
            imem_req_valid <= 1'b0;
            if_valid       <= 1'b0;
            if_pc          <= 32'h0000_0000;
            if_instr       <= 32'h0000_0000;
            if_pc_plus4    <= 32'h0000_0000;
        end else begin
            pc             <= pc_next;
            kill           <= kill_next;
            imem_req_valid <= (state_next == S_REQ);
            if_valid       <= (state_next == S_HOLD);
            if (capture) begin
                if_pc       <= pc;
                if_instr    <= imem_rsp_data;
                if_pc_plus4 <= pc_plus;
            end
`ifdef PC_ALIGN_CHECK_EN
            if (capture_err) begin
                if_pc       <= target_eff;
                if_instr    <= 32'h0000_0000;
                if_pc_plus4 <= target_plus;
            end
`endif
        end
    end

`ifdef PC_ALIGN_CHECK_EN
    // Alignment error flag lives exactly as long as the nop it tags is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_addr_err <= 1'b0;
        end else if (capture_err) begin
            if_addr_err <= 1'b1;
        end else if (state_next != S_HOLD) begin
            if_addr_err <= 1'b0;
        end
    end
`else
    logic unused_target_plus;
    assign unused_target_plus = ^target_plus;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb_pc_fetch_unit: directed self-checking bench for pc_fetch_unit.
// A small instruction-memory model lives inside the tick task: it returns
// 32'hC0DE_0000 | addr[15:0] a configurable number of cycles after accept.
// Optional build macro: PC_ALIGN_CHECK_EN (changes the misaligned-redirect case).
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic [31:0] if_pc_plus4;
`ifdef PC_ALIGN_CHECK_EN
    logic        if_addr_err;
`endif

    int          n_compared;
    int          n_mismatched;
    int          rsp_delay;
    logic        pend;
    int          pend_cnt;
    logic [31:0] pend_addr;

    pc_fetch_unit #(
        .RESET_VECTOR(32'h0000_0000),
        .PC_STEP     (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_target(redirect_target),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_pc_plus4    (if_pc_plus4)
`ifdef PC_ALIGN_CHECK_EN
        ,
        .if_addr_err    (if_addr_err)
`endif
    );

    // Free-running 10-time-unit clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock cycle plus the memory model; returns 1 unit after the rising edge.
    task automatic tick;
        logic        acc;
        logic [31:0] a;
        acc = imem_req_valid && imem_req_ready;
        a   = imem_req_addr;
        @(posedge clk);
        #1;
        imem_rsp_valid = 1'b0;
        if (acc) begin
            pend      = 1'b1;
            pend_addr = a;
            pend_cnt  = rsp_delay;
        end
        if (pend) begin
            if (pend_cnt <= 1) begin
                imem_rsp_valid = 1'b1;
                imem_rsp_data  = 32'hC0DE_0000 | {16'h0000, pend_addr[15:0]};
                pend           = 1'b0;
            end else begin
                pend_cnt = pend_cnt - 1;
            end
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        #1;
        repeat (2) tick;
        n_compared++;
        if ({imem_req_valid, if_valid} !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL reset_valids: got %b expected 00", {imem_req_valid, if_valid});
        end
        n_compared++;
        if ({if_pc, if_instr, if_pc_plus4, imem_req_addr} !== 128'h0) begin
            n_mismatched++;
            $display("[TB] FAIL reset_regs: got %h/%h/%h/%h expected all 0", if_pc, if_instr, if_pc_plus4, imem_req_addr);
        end
        rst_n = 1'b1;
        tick;
        n_compared++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL first_req: got %b/%h expected 1/00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_sequential;
        logic [31:0] exp_pc;
        for (int i = 0; i < 3; i++) begin
            exp_pc = 32'(4 * i);
            n_compared++;
            if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, exp_pc, 1'b0}) begin
                n_mismatched++;
                $display("[TB] FAIL seq_req%0d: got %b/%h/%b expected 1/%h/0", i, imem_req_valid, imem_req_addr, if_valid, exp_pc);
            end
            tick;
            n_compared++;
            if ({imem_req_valid, if_valid} !== 2'b00) begin
                n_mismatched++;
                $display("[TB] FAIL seq_wait%0d: got %b expected 00", i, {imem_req_valid, if_valid});
            end
            tick;
            n_compared++;
            if ({if_valid, if_pc, if_pc_plus4, if_instr} !== {1'b1, exp_pc, exp_pc + 32'd4, 32'hC0DE_0000 | exp_pc}) begin
                n_mismatched++;
                $display("[TB] FAIL seq_hold%0d: got %b/%h/%h/%h expected 1/%h/%h/%h", i, if_valid, if_pc, if_pc_plus4, if_instr,
                         exp_pc, exp_pc + 32'd4, 32'hC0DE_0000 | exp_pc);
            end
            if (i < 2) tick;
        end
    endtask

    task automatic test_stall;
        if_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick;
            n_compared++;
            if ({if_valid, imem_req_valid, if_pc, if_instr} !== {2'b10, 32'h8, 32'hC0DE_0008}) begin
                n_mismatched++;
                $display("[TB] FAIL stall%0d: got %b/%b/%h/%h expected 1/0/00000008/c0de0008", i, if_valid, imem_req_valid, if_pc, if_instr);
            end
        end
        if_ready = 1'b1;
        tick;
        n_compared++;
        if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 32'hC, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL stall_release: got %b/%h/%b expected 1/0000000c/0", imem_req_valid, imem_req_addr, if_valid);
        end
    endtask

    task automatic test_redirect_on_rsp;
        rst_n = 1'b0;
        pend  = 1'b0;
        imem_rsp_valid = 1'b0;
        #1;
        rst_n = 1'b1;
        tick;
        tick;
        tick;
        tick;
        tick;
        redirect_valid  = 1'b1;
        redirect_target = 32'h100;
        n_compared++;
        if ({imem_rsp_valid, imem_req_valid} !== 2'b10) begin
            n_mismatched++;
            $display("[TB] FAIL rdr_rsp_setup: got %b expected 10", {imem_rsp_valid, imem_req_valid});
        end
        tick;
        redirect_valid = 1'b0;
        n_compared++;
        if ({if_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h100}) begin
            n_mismatched++;
            $display("[TB] FAIL rdr_rsp_discard: got %b/%b/%h expected 0/1/00000100", if_valid, imem_req_valid, imem_req_addr);
        end
        tick;
        tick;
        n_compared++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h100, 32'hC0DE_0100}) begin
            n_mismatched++;
            $display("[TB] FAIL rdr_rsp_deliver: got %b/%h/%h expected 1/00000100/c0de0100", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect_wait;
        rsp_delay = 3;
        tick;
        tick;
        redirect_valid  = 1'b1;
        redirect_target = 32'h200;
        tick;
        redirect_valid = 1'b0;
        n_compared++;
        if ({imem_req_valid, if_valid} !== 2'b00) begin
            n_mismatched++;
            $display("[TB] FAIL rdr_wait_hold: got %b expected 00", {imem_req_valid, if_valid});
        end
        tick;
        tick;
        n_compared++;
        if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 32'h200, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL rdr_wait_stale: got %b/%h/%b expected 1/00000200/0", imem_req_valid, imem_req_addr, if_valid);
        end
        rsp_delay = 1;
        tick;
        tick;
        n_compared++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h200, 32'hC0DE_0200}) begin
            n_mismatched++;
            $display("[TB] FAIL rdr_wait_deliver: got %b/%h/%h expected 1/00000200/c0de0200", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_wrap;
        redirect_valid  = 1'b1;
        redirect_target = 32'hFFFF_FFFC;
        tick;
        redirect_valid = 1'b0;
        n_compared++;
        if ({if_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'hFFFF_FFFC}) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_hold_flush: got %b/%b/%h expected 0/1/fffffffc", if_valid, imem_req_valid, imem_req_addr);
        end
        tick;
        tick;
        n_compared++;
        if ({if_valid, if_pc, if_pc_plus4, if_instr} !== {1'b1, 32'hFFFF_FFFC, 32'h0, 32'hC0DE_FFFC}) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_deliver: got %b/%h/%h/%h expected 1/fffffffc/00000000/c0defffc", if_valid, if_pc, if_pc_plus4, if_instr);
        end
        tick;
        n_compared++;
        if ({imem_req_valid, imem_req_addr} !== {1'b1, 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL wrap_next_req: got %b/%h expected 1/00000000", imem_req_valid, imem_req_addr);
        end
    endtask

    task automatic test_back_to_back;
        rsp_delay = 3;
        tick;
        redirect_valid  = 1'b1;
        redirect_target = 32'h300;
        tick;
        redirect_target = 32'h400;
        tick;
        redirect_valid = 1'b0;
        tick;
        n_compared++;
        if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 32'h400, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_req: got %b/%h/%b expected 1/00000400/0", imem_req_valid, imem_req_addr, if_valid);
        end
        rsp_delay = 1;
        tick;
        tick;
        n_compared++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h400, 32'hC0DE_0400}) begin
            n_mismatched++;
            $display("[TB] FAIL b2b_deliver: got %b/%h/%h expected 1/00000400/c0de0400", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_redirect_req_accept;
        tick;
        redirect_valid  = 1'b1;
        redirect_target = 32'h500;
        tick;
        redirect_valid = 1'b0;
        tick;
        n_compared++;
        if ({if_valid, imem_req_valid, imem_req_addr} !== {2'b01, 32'h500}) begin
            n_mismatched++;
            $display("[TB] FAIL rdr_accept_kill: got %b/%b/%h expected 0/1/00000500", if_valid, imem_req_valid, imem_req_addr);
        end
        tick;
        tick;
        n_compared++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h500, 32'hC0DE_0500}) begin
            n_mismatched++;
            $display("[TB] FAIL rdr_accept_deliver: got %b/%h/%h expected 1/00000500/c0de0500", if_valid, if_pc, if_instr);
        end
    endtask

    task automatic test_align;
        tick;
        imem_req_ready  = 1'b0;
        redirect_valid  = 1'b1;
        redirect_target = 32'h102;
        tick;
        redirect_valid = 1'b0;
`ifdef PC_ALIGN_CHECK_EN
        n_compared++;
        if ({imem_req_valid, if_valid, if_addr_err, if_instr, if_pc, if_pc_plus4} !== {3'b011, 32'h0, 32'h102, 32'h106}) begin
            n_mismatched++;
            $display("[TB] FAIL align_err: got %b/%b/%b/%h/%h/%h expected 0/1/1/00000000/00000102/00000106",
                     imem_req_valid, if_valid, if_addr_err, if_instr, if_pc, if_pc_plus4);
        end
        imem_req_ready = 1'b1;
        tick;
        n_compared++;
        if ({imem_req_valid, imem_req_addr, if_addr_err} !== {1'b1, 32'h106, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL align_next: got %b/%h/%b expected 1/00000106/0", imem_req_valid, imem_req_addr, if_addr_err);
        end
`else
        n_compared++;
        if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 32'h100, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL align_force: got %b/%h/%b expected 1/00000100/0", imem_req_valid, imem_req_addr, if_valid);
        end
        imem_req_ready = 1'b1;
        tick;
        tick;
        n_compared++;
        if ({if_valid, if_pc, if_pc_plus4} !== {1'b1, 32'h100, 32'h104}) begin
            n_mismatched++;
            $display("[TB] FAIL align_deliver: got %b/%h/%h expected 1/00000100/00000104", if_valid, if_pc, if_pc_plus4);
        end
`endif
    endtask

    task automatic test_reset_midflight;
        rsp_delay = 2;
        tick;
        tick;
        rst_n = 1'b0;
        #1;
        n_compared++;
        if ({imem_req_valid, if_valid, if_pc, imem_req_addr} !== {2'b00, 32'h0, 32'h0}) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_async: got %b/%b/%h/%h expected 0/0/0/0", imem_req_valid, if_valid, if_pc, imem_req_addr);
        end
        tick;
        rst_n = 1'b1;
        tick;
        n_compared++;
        if ({imem_req_valid, imem_req_addr, if_valid} !== {1'b1, 32'h0, 1'b0}) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_req: got %b/%h/%b expected 1/00000000/0", imem_req_valid, imem_req_addr, if_valid);
        end
        tick;
        tick;
        n_compared++;
        if (if_valid !== 1'b0) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_wait: got %b expected 0", if_valid);
        end
        tick;
        n_compared++;
        if ({if_valid, if_pc, if_instr} !== {1'b1, 32'h0, 32'hC0DE_0000}) begin
            n_mismatched++;
            $display("[TB] FAIL midreset_deliver: got %b/%h/%h expected 1/00000000/c0de0000", if_valid, if_pc, if_instr);
        end
    endtask

    // Drives the whole directed sequence and prints the summary.
    initial begin
        n_compared      = 0;
        n_mismatched    = 0;
        rsp_delay       = 1;
        pend            = 1'b0;
        pend_cnt        = 0;
        pend_addr       = 32'h0;
        rst_n           = 1'b0;
        imem_req_ready  = 1'b1;
        imem_rsp_valid  = 1'b0;
        imem_rsp_data   = 32'h0;
        redirect_valid  = 1'b0;
        redirect_target = 32'h0;
        if_ready        = 1'b1;
        test_reset;
        test_sequential;
        test_stall;
        test_redirect_on_rsp;
        test_redirect_wait;
        test_wrap;
        test_back_to_back;
        test_redirect_req_accept;
        test_align;
        test_reset_midflight;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
